// File: rtl/ball_motion_sequencer.sv
// ball_motion_sequencer
//
// Purpose: holds position and velocity state for N bouncing balls. On each accepted
// frame-start pulse it steps every slot once, one slot per pclk in index order. Each
// axis bounces off 0 and off (resolution - ball size). A configuration port rewrites
// a slot while idle. A one-cycle-latency read port exposes any slot's position.
//
// Ports:
//   pclk, reset_n         pixel clock; asynchronous active-low reset
//   i_frame_start         one-cycle pulse that requests an update pass
//   i_freeze              suppresses new passes (a pass in flight still completes)
//   cfg_we, cfg_idx,      slot configuration write (position is clamped to the
//   cfg_x/y, cfg_dx/dy    legal range; direction bits are cleared)
//   rd_idx, o_rd_x/y      registered read port (0 for out-of-range index)
//   o_busy                high while slots are being stepped
//   o_done                one-cycle pulse when a pass completes
//   o_overrun             one-cycle pulse when a frame start is dropped (busy)
//   o_cfg_drop            one-cycle pulse when a config write is dropped (busy)
//   o_frame_cnt           completed-pass counter, wraps 255 -> 0
module ball_motion_sequencer #(
  parameter int N      = 8,
  parameter int X_RES  = 640,
  parameter int Y_RES  = 480,
  parameter int BALL_W = 16,
  parameter int BALL_H = 16,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          i_frame_start,
  input  logic          i_freeze,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [10:0]   cfg_x,
  input  logic [10:0]   cfg_y,
  input  logic [2:0]    cfg_dx,
  input  logic [2:0]    cfg_dy,
  input  logic [IW-1:0] rd_idx,
  output logic [10:0]   o_rd_x,
  output logic [10:0]   o_rd_y,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_overrun,
  output logic          o_cfg_drop,
  output logic [7:0]    o_frame_cnt
);

  localparam logic [10:0] XMax = 11'(X_RES - BALL_W);
  localparam logic [10:0] YMax = 11'(Y_RES - BALL_H);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Control state
  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;
  logic          done_q;
  logic          overrun_q;
  logic          cfg_drop_q;
  logic          armed_q;
  logic [7:0]    frame_cnt_q;

  // Per-slot state
  logic [10:0]   x_q  [N];
  logic [10:0]   y_q  [N];
  logic [2:0]    dx_q [N];
  logic [2:0]    dy_q [N];
  logic [N-1:0]  dir_x_q;
  logic [N-1:0]  dir_y_q;

  // Read port
  logic [10:0]   rd_x_q;
  logic [10:0]   rd_y_q;

  // Decoded strobes
  logic          cfg_idx_ok;
  logic          rd_idx_ok;
  logic          cfg_wr;
  logic          cfg_drop_d;
  logic          start_ok;
  logic          overrun_d;
  logic          last_slot;
  logic [11:0]   step_x;
  logic [11:0]   step_y;
  logic [10:0]   cfg_x_clamped;
  logic [10:0]   cfg_y_clamped;

  // One axis step. Returns {new_dir, new_pos}. A zero step holds both position and
  // direction; the decreasing branch compares before subtracting so it never wraps.
  function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic [2:0] d,
                                            input logic dir, input logic [10:0] lim);
    logic [11:0] sum;
    logic [10:0] npos;
    logic        ndir;
    npos = pos;
    ndir = dir;
    sum  = {1'b0, pos} + {9'b0, d};
    if (d != 3'd0) begin
      if (!dir) begin
        if (sum >= {1'b0, lim}) begin
          npos = lim;
          ndir = 1'b1;
        end else begin
          npos = sum[10:0];
        end
      end else begin
        if (pos <= {8'b0, d}) begin
          npos = '0;
          ndir = 1'b0;
        end else begin
          npos = pos - {8'b0, d};
        end
      end
    end
    return {ndir, npos};
  endfunction

  always_comb begin
    cfg_idx_ok    = int'(cfg_idx) < N;
    rd_idx_ok     = int'(rd_idx) < N;
    cfg_wr        = cfg_we && cfg_idx_ok && (state_q == StIdle);
    // Out-of-range indices are silently ignored, so they never count as a drop.
    cfg_drop_d    = cfg_we && cfg_idx_ok && (state_q != StIdle);
    // A frozen frame start is ignored outright: neither a pass nor an overrun.
    start_ok      = i_frame_start && !i_freeze && armed_q && (state_q == StIdle);
    overrun_d     = i_frame_start && !i_freeze && (state_q != StIdle);
    last_slot     = int'(idx_q) == (N - 1);
    step_x        = step_axis(x_q[idx_q], dx_q[idx_q], dir_x_q[idx_q], XMax);
    step_y        = step_axis(y_q[idx_q], dy_q[idx_q], dir_y_q[idx_q], YMax);
    cfg_x_clamped = (cfg_x > XMax) ? XMax : cfg_x;
    cfg_y_clamped = (cfg_y > YMax) ? YMax : cfg_y;
  end

  // Sequencing FSM with registered status outputs
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_drop_q  <= 1'b0;
      armed_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      // armed_q holds off frame starts until the second edge after reset release.
      armed_q    <= 1'b1;
      done_q     <= 1'b0;
      overrun_q  <= overrun_d;
      cfg_drop_q <= cfg_drop_d;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q <= StRun;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (last_slot) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Slot storage. Config writes only happen in idle and steps only in run, so the two
  // write paths never target the same edge.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        x_q[i]     <= 11'((i * 37) % (X_RES - BALL_W));
        y_q[i]     <= 11'((i * 23) % (Y_RES - BALL_H));
        dx_q[i]    <= 3'(1 + (i % 4));
        dy_q[i]    <= 3'(1 + ((i + 1) % 4));
        dir_x_q[i] <= 1'b0;
        dir_y_q[i] <= 1'b0;
      end
    end else begin
      if (cfg_wr) begin
        x_q[cfg_idx]     <= cfg_x_clamped;
        y_q[cfg_idx]     <= cfg_y_clamped;
        dx_q[cfg_idx]    <= cfg_dx;
        dy_q[cfg_idx]    <= cfg_dy;
        dir_x_q[cfg_idx] <= 1'b0;
        dir_y_q[cfg_idx] <= 1'b0;
      end
      if (state_q == StRun) begin
        x_q[idx_q]     <= step_x[10:0];
        dir_x_q[idx_q] <= step_x[11];
        y_q[idx_q]     <= step_y[10:0];
        dir_y_q[idx_q] <= step_y[11];
      end
    end
  end

  // Read port: samples the pre-edge slot value, so a same-cycle write reads old data.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end else if (rd_idx_ok) begin
      rd_x_q <= x_q[rd_idx];
      rd_y_q <= y_q[rd_idx];
    end else begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end
  end

  assign o_rd_x      = rd_x_q;
  assign o_rd_y      = rd_y_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_overrun   = overrun_q;
  assign o_cfg_drop  = cfg_drop_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Self-checking bench for ball_motion_sequencer (default parameters, N = 8).
module tb_ball_motion_sequencer;

  localparam int N = 8;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic        i_frame_start;
  logic        i_freeze;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [10:0] cfg_x;
  logic [10:0] cfg_y;
  logic [2:0]  cfg_dx;
  logic [2:0]  cfg_dy;
  logic [2:0]  rd_idx;
  logic [10:0] o_rd_x;
  logic [10:0] o_rd_y;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;
  logic        o_cfg_drop;
  logic [7:0]  o_frame_cnt;

  always #5 pclk = ~pclk;

  ball_motion_sequencer #(.N(N)) dut (
    .pclk         (pclk),
    .reset_n      (reset_n),
    .i_frame_start(i_frame_start),
    .i_freeze     (i_freeze),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_x        (cfg_x),
    .cfg_y        (cfg_y),
    .cfg_dx       (cfg_dx),
    .cfg_dy       (cfg_dy),
    .rd_idx       (rd_idx),
    .o_rd_x       (o_rd_x),
    .o_rd_y       (o_rd_y),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overrun    (o_overrun),
    .o_cfg_drop   (o_cfg_drop),
    .o_frame_cnt  (o_frame_cnt)
  );

  typedef struct {
    int idx;
    int rst_x;
    int rst_y;
    int p1_x;
    int p1_y;
  } slot_vec_t;

  slot_vec_t  vecs [N];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_cnt  = 8'd0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic read_slot(input int idx, output int x, output int y);
    rd_idx = 3'(idx);
    tick();
    x = int'(o_rd_x);
    y = int'(o_rd_y);
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int dx, input int dy);
    cfg_idx = 3'(idx);
    cfg_x   = 11'(x);
    cfg_y   = 11'(y);
    cfg_dx  = 3'(dx);
    cfg_dy  = 3'(dy);
    cfg_we  = 1'b1;
    tick();
    cfg_we  = 1'b0;
    check("cfg_drop_idle", int'(o_cfg_drop), 0);
  endtask

  // One full pass; any cfg_we already driven by the caller rides the start cycle.
  task automatic run_pass();
    int busy_cnt, done_cnt, done_k, busy_first;
    busy_cnt = 0;
    done_cnt = 0;
    done_k   = 0;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    cfg_we        = 1'b0;
    busy_first    = int'(o_busy);
    for (int k = 1; k <= N + 2; k++) begin
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    check("pass_busy_at_T+1", busy_first, 1);
    check("pass_busy_cycles", busy_cnt, N);
    check("pass_done_offset", done_k, N + 1);
    check("pass_done_count", done_cnt, 1);
    check("pass_frame_cnt", int'(o_frame_cnt), int'(exp_cnt));
  endtask

  task automatic check_reset_table();
    int x, y;
    for (int i = 0; i < N; i++) begin
      read_slot(vecs[i].idx, x, y);
      check($sformatf("rst_x[%0d]", i), x, vecs[i].rst_x);
      check($sformatf("rst_y[%0d]", i), y, vecs[i].rst_y);
    end
  endtask

  initial begin
    int x, y;
    int ov_k, ov_cnt, done_k, done_cnt, drop_k, drop_cnt, busy_cnt;

    vecs[0] = '{0,   0,   0,   1,   2};
    vecs[1] = '{1,  37,  23,  39,  26};
    vecs[2] = '{2,  74,  46,  77,  50};
    vecs[3] = '{3, 111,  69, 115,  70};
    vecs[4] = '{4, 148,  92, 149,  94};
    vecs[5] = '{5, 185, 115, 187, 118};
    vecs[6] = '{6, 222, 138, 225, 142};
    vecs[7] = '{7, 259, 161, 263, 162};

    reset_n = 1'b0;
    i_frame_start = 1'b0;
    i_freeze = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_x = '0;
    cfg_y = '0;
    cfg_dx = '0;
    cfg_dy = '0;
    rd_idx = 3'd1;
    repeat (2) tick();
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_overrun", int'(o_overrun), 0);
    check("rst_cfg_drop", int'(o_cfg_drop), 0);
    check("rst_frame_cnt", int'(o_frame_cnt), 0);
    check("rst_rd_x", int'(o_rd_x), 0);
    check("rst_rd_y", int'(o_rd_y), 0);
    reset_n = 1'b1;

    // Reset contents and a first pass from them
    check_reset_table();
    check("frame_cnt_after_reset", int'(o_frame_cnt), 0);
    run_pass();
    for (int i = 0; i < N; i++) begin
      read_slot(vecs[i].idx, x, y);
      check($sformatf("pass1_x[%0d]", i), x, vecs[i].p1_x);
      check($sformatf("pass1_y[%0d]", i), y, vecs[i].p1_y);
    end

    // Config write while reading the same slot: read returns the old value
    rd_idx = 3'd2;
    cfg_write(2, 620, 100, 7, 0);
    check("rd_during_wr_x", int'(o_rd_x), 77);
    check("rd_during_wr_y", int'(o_rd_y), 50);
    read_slot(2, x, y);
    check("cfg2_x", x, 620);
    check("cfg2_y", y, 100);
    cfg_write(5, 2000, 2000, 0, 0);
    read_slot(5, x, y);
    check("clamp_x", x, 624);
    check("clamp_y", y, 464);

    // Right-edge bounce then retreat
    run_pass();
    read_slot(2, x, y);
    check("bounce_x", x, 624);
    check("bounce_y_hold", y, 100);
    run_pass();
    read_slot(2, x, y);
    check("retreat_x", x, 617);
    read_slot(5, x, y);
    check("zero_step_x", x, 624);
    check("zero_step_y", y, 464);

    // Left-edge bounce without underflow: 624 -> ... -> 9 -> 4 -> 0 -> 5
    cfg_write(3, 620, 0, 5, 0);
    run_pass();
    read_slot(3, x, y);
    check("s3_top_x", x, 624);
    for (int j = 0; j < 124; j++) run_pass();
    read_slot(3, x, y);
    check("s3_near_left_x", x, 4);
    run_pass();
    read_slot(3, x, y);
    check("s3_left_clamp_x", x, 0);
    run_pass();
    read_slot(3, x, y);
    check("s3_after_left_x", x, 5);

    // Config accepted in the same cycle as the frame start
    cfg_idx = 3'd3;
    cfg_x   = 11'd100;
    cfg_y   = 11'd10;
    cfg_dx  = 3'd0;
    cfg_dy  = 3'd0;
    cfg_we  = 1'b1;
    run_pass();
    read_slot(3, x, y);
    check("cfg_with_start_x", x, 100);
    check("cfg_with_start_y", y, 10);

    // Frozen frame start is ignored
    i_freeze = 1'b1;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    check("freeze_busy", int'(o_busy), 0);
    check("freeze_overrun", int'(o_overrun), 0);
    repeat (N + 2) tick();
    check("freeze_done", int'(o_done), 0);
    check("freeze_frame_cnt", int'(o_frame_cnt), int'(exp_cnt));
    i_freeze = 1'b0;

    // Frame start at T+3 of a running pass
    ov_k = 0; ov_cnt = 0; done_k = 0; done_cnt = 0;
    i_frame_start = 1'b1;
    tick();
    for (int k = 1; k <= N + 3; k++) begin
      if (o_overrun) begin
        ov_cnt++;
        if (ov_k == 0) ov_k = k;
      end
      if (o_done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      i_frame_start = (k == 3);
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    check("overrun_offset", ov_k, 4);
    check("overrun_count", ov_cnt, 1);
    check("overrun_done_offset", done_k, N + 1);
    check("overrun_done_count", done_cnt, 1);
    check("overrun_frame_cnt", int'(o_frame_cnt), int'(exp_cnt));

    // Config write during RUN is dropped; freeze raised mid-pass does not abort
    drop_k = 0; drop_cnt = 0; done_cnt = 0;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    for (int k = 1; k <= N + 3; k++) begin
      if (o_cfg_drop) begin
        drop_cnt++;
        if (drop_k == 0) drop_k = k;
      end
      if (o_done) done_cnt++;
      if (k == 2) begin
        cfg_idx  = 3'd5;
        cfg_x    = 11'd0;
        cfg_y    = 11'd0;
        cfg_dx   = 3'd1;
        cfg_dy   = 3'd1;
        cfg_we   = 1'b1;
        i_freeze = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end
    i_freeze = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("cfg_drop_offset", drop_k, 3);
    check("cfg_drop_count", drop_cnt, 1);
    check("freeze_midpass_done", done_cnt, 1);
    check("freeze_midpass_cnt", int'(o_frame_cnt), int'(exp_cnt));
    read_slot(5, x, y);
    check("dropped_cfg_x", x, 624);
    check("dropped_cfg_y", y, 464);

    // Frame counter wrap 255 -> 0
    for (int j = 0; j < 256 && exp_cnt != 8'd0; j++) run_pass();
    check("frame_cnt_wrap", int'(o_frame_cnt), 0);

    // Reset at T+4 of a pass discards it
    done_cnt = 0;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("midreset_busy", int'(o_busy), 0);
    for (int k = 0; k < N; k++) begin
      if (o_done) done_cnt++;
      tick();
    end
    // Frame start on the first edge after release must not be accepted
    reset_n = 1'b1;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < N + 2; k++) begin
      if (o_done) done_cnt++;
      if (o_busy) busy_cnt++;
      tick();
    end
    check("midreset_done_count", done_cnt, 0);
    check("early_start_busy", busy_cnt, 0);
    exp_cnt = 8'd0;
    check("midreset_frame_cnt", int'(o_frame_cnt), 0);
    check_reset_table();
    run_pass();
    read_slot(0, x, y);
    check("post_reset_pass_x0", x, 1);
    check("post_reset_pass_y0", y, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion before limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ball_motion_sequencer.md
BALL_MOTION_SEQUENCER -- requirements
Module: ball_motion_sequencer

Interface
REQ-001 Parameter N, default 8: number of ball slots.
REQ-002 Parameter X_RES, default 640; parameter Y_RES, default 480: active area.
REQ-003 Parameter BALL_W, default 16; parameter BALL_H, default 16: ball size in pixels.
REQ-004 pclk  in  1  pixel clock; the block's only clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_frame_start  in  1  one-cycle pulse at the start of vertical blanking.
REQ-007 i_freeze  in  1  while high, frame updates are suppressed.
REQ-008 cfg_we  in  1  configuration write strobe.
REQ-009 cfg_idx  in  clog2(N)  slot index for the configuration write.
REQ-010 cfg_x, cfg_y  in  11 each  new position; cfg_dx, cfg_dy  in  3 each  new step size.
REQ-011 rd_idx  in  clog2(N)  slot index for the read port.
REQ-012 o_rd_x, o_rd_y  out  11 each  registered position of slot rd_idx.
REQ-013 o_busy  out  1  high while slots are being updated.
REQ-014 o_done  out  1  one-cycle pulse when an update pass completes.
REQ-015 o_overrun  out  1  one-cycle pulse when i_frame_start is dropped because the block is busy.
REQ-016 o_cfg_drop  out  1  one-cycle pulse when cfg_we is dropped because the block is busy.
REQ-017 o_frame_cnt  out  8  count of completed update passes, wrapping 255 -> 0.

Function
REQ-018 Per-slot state SHALL be held in flops: x[11], y[11], dx[3], dy[3], dir_x, dir_y (0 = increasing).
REQ-019 FSM states SHALL be IDLE, RUN and DONE.
REQ-020 IDLE -> RUN on i_frame_start=1 with i_freeze=0; the slot index clears to 0 and o_busy rises the next cycle.
REQ-021 RUN SHALL update exactly one slot per cycle in index order 0..N-1; after slot N-1 the FSM goes to DONE.
REQ-022 DONE SHALL last one cycle, assert o_done, increment o_frame_cnt and return to IDLE.
REQ-023 Latency SHALL be: i_frame_start at cycle T -> o_done at cycle T+N+1; o_busy is high in cycles T+1..T+N.
REQ-024 Horizontal step SHALL be: with dir_x=0, if x+dx >= X_RES-BALL_W then x <= X_RES-BALL_W and dir_x <= 1, else x <= x+dx.
REQ-025 Horizontal step SHALL be: with dir_x=1, if x <= dx then x <= 0 and dir_x <= 0, else x <= x-dx; no unsigned underflow is permitted.
REQ-026 The vertical axis SHALL behave identically, using Y_RES, BALL_H, dy and dir_y.
REQ-027 A slot with dx=0 (or dy=0) SHALL hold that coordinate and its direction.
REQ-028 cfg_we in IDLE SHALL write x, y, dx and dy of slot cfg_idx the next cycle and clear both dir bits.
REQ-029 Configuration writes SHALL clamp cfg_x to X_RES-BALL_W and cfg_y to Y_RES-BALL_H.
REQ-030 cfg_we with cfg_idx >= N SHALL be ignored, with no pulse on o_cfg_drop.
REQ-031 cfg_we while o_busy=1 or in DONE SHALL be dropped and SHALL pulse o_cfg_drop the next cycle.
REQ-032 cfg_we in the same cycle as an accepted i_frame_start SHALL be written first; the pass then starts normally.
REQ-033 i_frame_start in RUN or DONE SHALL be dropped and SHALL pulse o_overrun the next cycle.
REQ-034 i_frame_start with i_freeze=1 SHALL be ignored: no pass runs, o_frame_cnt is unchanged and no o_overrun pulse occurs.
REQ-035 Raising i_freeze mid-pass SHALL NOT abort the pass.
REQ-036 The read port SHALL have one-cycle latency and return the value committed before the current edge.
REQ-037 A read of a slot being written in the same cycle SHALL return the old value.
REQ-038 rd_idx >= N SHALL return 0 on both o_rd_x and o_rd_y.

Reset
REQ-039 reset_n=0 SHALL asynchronously force IDLE, slot index 0, o_busy=0, o_done=0, o_overrun=0, o_cfg_drop=0, o_frame_cnt=0, o_rd_x=0 and o_rd_y=0.
REQ-040 reset_n=0 SHALL load slot i with x=(i*37)%(X_RES-BALL_W), y=(i*23)%(Y_RES-BALL_H), dx=1+i%4, dy=1+(i+1)%4, dir_x=0 and dir_y=0.
REQ-041 Reset asserted mid-pass SHALL discard the pass: no o_done pulse, and all slots return to their REQ-040 values.
REQ-042 The first i_frame_start is accepted no earlier than the second pclk edge after reset_n deasserts.

Verification
REQ-043 Reset, then rd_idx=1 -> o_rd_x=37 and o_rd_y=23 one cycle later; o_frame_cnt=0.
REQ-044 Single i_frame_start with N=8 -> o_busy high for 8 cycles, o_done at T+9, o_frame_cnt=1, slot0 x=1 and y=2.
REQ-045 cfg slot2 x=620, dx=7, dir 0, then one pass -> x=624 and dir_x=1; a second pass -> x=617.
REQ-046 cfg slot3 x=3, dx=5 with dir_x=1 forced by a prior bounce -> next pass gives x=0 and dir_x=0, with no wrap to a large value.
REQ-047 i_frame_start at T+3 of a pass -> o_overrun pulse at T+4, a single o_done, and o_frame_cnt incremented by 1.
REQ-048 cfg_we during RUN -> o_cfg_drop pulse and target slot unchanged; reset_n low at T+4 -> no o_done and slots equal to their REQ-040 values.
